// File: rtl/adder_issue_ctrl.sv
// Issue stage for a fixed-latency registered adder: operand stream in, tagged in-flight tracking, result FIFO out.
// Optional `ADDER_ISSUE_STATS_EN adds saturating issued/completed counters.
module adder_issue_ctrl #(
  parameter int N         = 4,
  parameter int ADDER_LAT = 2,
  parameter int DEPTH     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_op1,
  input  logic [N-1:0]           in_op2,
  output logic [N-1:0]           add_operand1,
  output logic [N-1:0]           add_operand2,
  input  logic [N-1:0]           add_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(DEPTH):0] outstanding
`ifdef ADDER_ISSUE_STATS_EN
  ,
  output logic [15:0]            issued_cnt,
  output logic [15:0]            completed_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]         op1_q, op1_d, op2_q, op2_d;
  logic [ADDER_LAT-1:0] tag_q, tag_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [N-1:0]         mem_q [DEPTH];
  logic [CW-1:0]        inflight;
  logic                 accept, push, pop;

  // Credit view: everything that will eventually occupy a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < ADDER_LAT; k++) begin
      inflight = inflight + CW'(tag_q[k]);
    end
  end

  assign outstanding  = count_q + inflight;
  assign in_ready     = !reset && (outstanding < DEPTH_C);
  assign accept       = in_valid && in_ready;
  assign push         = tag_q[ADDER_LAT-1];
  assign out_valid    = !reset && (count_q != '0);
  assign pop          = out_valid && out_ready;
  assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign add_operand1 = op1_q;
  assign add_operand2 = op2_q;

  always_comb begin
    op1_d    = op1_q;
    op2_d    = op2_q;
    tag_d    = '0;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (accept) begin
      op1_d = in_op1;
      op2_d = in_op2;
    end

    tag_d[0] = accept;
    for (int unsigned k = 1; k < ADDER_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op1_q    <= '0;
      op2_q    <= '0;
      tag_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      tag_q    <= tag_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: count_q gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= add_result;
  end

`ifdef ADDER_ISSUE_STATS_EN
  logic [15:0] issued_q, issued_d, completed_q, completed_d;

  always_comb begin
    issued_d    = issued_q;
    completed_d = completed_q;
    if (accept && (issued_q != '1))  issued_d    = issued_q + 16'd1;
    if (pop && (completed_q != '1))  completed_d = completed_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q    <= '0;
      completed_q <= '0;
    end else begin
      issued_q    <= issued_d;
      completed_q <= completed_d;
    end
  end

  assign issued_cnt    = issued_q;
  assign completed_cnt = completed_q;
`endif

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && (count_q == DEPTH_C) && !pop));

  a_credit_bound: assert property (@(posedge clock) disable iff (reset)
    outstanding <= DEPTH_C);

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Directed bench for adder_issue_ctrl with a one-register adder model on the operand outputs.
// Define ADDER_ISSUE_STATS_EN for both files to exercise the statistics counters.
module tb_adder_issue_ctrl;
  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_op1 = '0, in_op2 = '0;
  logic [N-1:0]  add_operand1, add_operand2, add_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_data;
  logic [OW-1:0] outstanding;
`ifdef ADDER_ISSUE_STATS_EN
  logic [15:0]   issued_cnt, completed_cnt;
`endif

  int checks = 0;
  int passes = 0;

  adder_issue_ctrl #(.N(N), .ADDER_LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .add_operand1 (add_operand1),
    .add_operand2 (add_operand2),
    .add_result   (add_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .outstanding  (outstanding)
`ifdef ADDER_ISSUE_STATS_EN
    ,
    .issued_cnt   (issued_cnt),
    .completed_cnt(completed_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Registered adder: operands launched at edge t give a stable sum from edge t+1.
  always_ff @(posedge clock) add_result <= add_operand1 + add_operand2;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_one(input logic [N-1:0] a, input logic [N-1:0] b);
    in_op1   = a;
    in_op2   = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid); else passes++;
    checks++; if (out_data !== 4'h0) $display("FAIL rst_out_data got %h want 0", out_data); else passes++;
    checks++; if (outstanding !== 3'd0) $display("FAIL rst_outstanding got %0d want 0", outstanding); else passes++;
    checks++; if (add_operand1 !== 4'h0 || add_operand2 !== 4'h0)
      $display("FAIL rst_operands got %h/%h want 0/0", add_operand1, add_operand2); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %0b want 1", in_ready); else passes++;
  endtask

  task automatic test_single_op();
    out_ready = 1'b1;
    in_op1 = 4'h3; in_op2 = 4'h4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (add_operand1 !== 4'h3 || add_operand2 !== 4'h4)
      $display("FAIL single_operands got %h/%h want 3/4", add_operand1, add_operand2); else passes++;
    checks++; if (outstanding !== 3'd1) $display("FAIL single_outst_t0 got %0d want 1", outstanding); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_t0 got %0b want 0", out_valid); else passes++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_t1 got %0b want 0", out_valid); else passes++;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h7)
      $display("FAIL single_result_t2 got v=%0b d=%h want v=1 d=7", out_valid, out_data); else passes++;
    checks++; if (outstanding !== 3'd1) $display("FAIL single_outst_t2 got %0d want 1", outstanding); else passes++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_t3 got %0b want 0", out_valid); else passes++;
    checks++; if (outstanding !== 3'd0) $display("FAIL single_outst_t3 got %0d want 0", outstanding); else passes++;
  endtask

  task automatic test_wrap();
    logic [N-1:0] va [2] = '{4'hF, 4'h8};
    logic [N-1:0] vb [2] = '{4'h1, 4'h8};
    bit got;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue_one(va[i], vb[i]);
      wait_valid(got);
      checks++; if (!got || out_data !== 4'h0)
        $display("FAIL wrap_%0d got v=%0b d=%h want v=1 d=0", i, got, out_data); else passes++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] k = 4'd1;
    int accepted = 0;
    int recv = 0;
    logic [N-1:0] exp_v;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_op1 = k; in_op2 = k;
      if (in_ready) begin accepted++; k = k + 4'd1; end
      tick();
    end
    checks++; if (accepted != 4) $display("FAIL bp_accepted got %0d want 4", accepted); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %0b want 0", in_ready); else passes++;
    checks++; if (outstanding !== 3'd4) $display("FAIL bp_outstanding got %0d want 4", outstanding); else passes++;
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h2)
      $display("FAIL bp_head got v=%0b d=%h want v=1 d=2", out_valid, out_data); else passes++;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && recv < 6; c++) begin
      in_valid = (k <= 4'd6);
      in_op1 = k; in_op2 = k;
      if (in_valid && in_ready) k = k + 4'd1;
      if (out_valid) begin
        exp_v = 4'(2 * (recv + 1));
        checks++; if (out_data !== exp_v)
          $display("FAIL bp_order_%0d got %h want %h", recv, out_data, exp_v); else passes++;
        recv++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (recv != 6) $display("FAIL bp_drain got %0d results want 6", recv); else passes++;
  endtask

  task automatic test_streaming();
    logic [N-1:0] exp_q [$];
    int accepted = 0, recv = 0, recv_loop = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_op1 = N'($urandom);
      in_op2 = N'($urandom);
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL stream_spurious got %h want none", out_data);
        else if (out_data !== exp_q[0]) $display("FAIL stream_data_%0d got %h want %h", recv, out_data, exp_q[0]);
        else passes++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        recv++; recv_loop++;
      end
      checks++; if (outstanding > 3'(LAT + 1))
        $display("FAIL stream_outst got %0d want <= %0d", outstanding, LAT + 1); else passes++;
      if (in_ready) begin
        exp_q.push_back(N'(in_op1 + in_op2));
        accepted++;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (out_valid) begin
        checks++; if (out_data !== exp_q[0])
          $display("FAIL stream_data_%0d got %h want %h", recv, out_data, exp_q[0]); else passes++;
        void'(exp_q.pop_front());
        recv++;
      end
      tick();
    end
    checks++; if (accepted != 20) $display("FAIL stream_accepted got %0d want 20", accepted); else passes++;
    checks++; if (recv_loop != 17) $display("FAIL stream_rate got %0d want 17", recv_loop); else passes++;
    checks++; if (recv != 20) $display("FAIL stream_total got %0d want 20", recv); else passes++;
  endtask

  task automatic test_reset_midop();
    bit got;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 5; i < 8; i++) begin
      in_op1 = 4'(i); in_op2 = 4'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (outstanding !== 3'd3) $display("FAIL midop_outst_pre got %0d want 3", outstanding); else passes++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL midop_valid got %0b want 0", out_valid); else passes++;
    checks++; if (outstanding !== 3'd0) $display("FAIL midop_outst got %0d want 0", outstanding); else passes++;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0)
        $display("FAIL midop_stale_%0d got v=%0b d=%h want v=0", c, out_valid, out_data); else passes++;
    end
    issue_one(4'h1, 4'h1);
    wait_valid(got);
    checks++; if (!got || out_data !== 4'h2)
      $display("FAIL midop_new got v=%0b d=%h want v=1 d=2", got, out_data); else passes++;
    tick();
  endtask

`ifdef ADDER_ISSUE_STATS_EN
  task automatic test_stats();
    bit got;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (issued_cnt !== 16'd0 || completed_cnt !== 16'd0)
      $display("FAIL stats_reset got %0d/%0d want 0/0", issued_cnt, completed_cnt); else passes++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_one(4'(i), 4'h1);
      wait_valid(got);
      tick();
    end
    out_ready = 1'b0;
    issue_one(4'h2, 4'h2);
    issue_one(4'h3, 4'h3);
    tick(); tick(); tick();
    checks++; if (issued_cnt !== 16'd5) $display("FAIL stats_issued got %0d want 5", issued_cnt); else passes++;
    checks++; if (completed_cnt !== 16'd3) $display("FAIL stats_completed got %0d want 3", completed_cnt); else passes++;
    out_ready = 1'b1;
    tick(); tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_wrap();
    test_backpressure();
    test_streaming();
    test_reset_midop();
`ifdef ADDER_ISSUE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
